// File: rtl/frame_align_pkg.sv
// Shared types and helpers for the ADC frame-lane word aligner.
package frame_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_VERIFY,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    localparam logic [7:0] DEFAULT_PATTERN = 8'hF0;

    // Bits needed to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/frame_aligner.sv
// Frame-lane word aligner: slips the deserializer until the parallel word equals
// the frame pattern, then tracks lock and re-aligns after a run of misses.
module frame_aligner
    import frame_align_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] PATTERN       = WIDTH'(DEFAULT_PATTERN),
    parameter int               MAX_SLIPS     = 2 * WIDTH,
    parameter int               SETTLE_CYCLES = 4,
    parameter int               LOCK_COUNT    = 16,
    parameter int               LOSS_COUNT    = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             en_i,
    input  logic [WIDTH-1:0]                 frame_i,
    output logic                             bitslip_o,
    output logic                             locked_o,
    output logic                             fail_o,
    output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_count_o
);

    localparam int SW = $clog2(MAX_SLIPS + 1);
    localparam int MW = cnt_w(LOCK_COUNT);
    localparam int LW = cnt_w(LOSS_COUNT);
    localparam int TW = cnt_w(SETTLE_CYCLES);

    localparam logic [SW-1:0] SLIP_MAX    = SW'(MAX_SLIPS);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(LOCK_COUNT - 1);
    localparam logic [LW-1:0] MISS_LAST   = LW'(LOSS_COUNT - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES);

    state_t        state, state_next;
    logic [SW-1:0] slip_cnt, slip_next;
    logic [MW-1:0] match_cnt, match_next;
    logic [LW-1:0] miss_cnt, miss_next;
    logic [TW-1:0] settle_cnt, settle_next;
    logic          is_match;
    logic          can_slip;

    assign is_match = (frame_i == PATTERN);
    assign can_slip = (slip_cnt < SLIP_MAX);

    always_comb begin
        state_next  = state;
        slip_next   = slip_cnt;
        match_next  = match_cnt;
        miss_next   = miss_cnt;
        settle_next = settle_cnt;

        case (state)
            ST_IDLE: begin
                slip_next   = '0;
                match_next  = '0;
                miss_next   = '0;
                settle_next = '0;
                state_next  = ST_CHECK;
            end
            ST_CHECK: begin
                if (is_match) begin
                    match_next = MW'(1);
                    state_next = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                end else begin
                    match_next = '0;
                    state_next = can_slip ? ST_SLIP : ST_FAIL;
                end
            end
            ST_SLIP: begin
                if (can_slip) slip_next = slip_cnt + SW'(1);
                settle_next = SETTLE_LOAD;
                state_next  = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Words here still reflect the pre-slip alignment; just count down.
                if (settle_cnt <= TW'(1)) begin
                    settle_next = '0;
                    state_next  = ST_CHECK;
                end else begin
                    settle_next = settle_cnt - TW'(1);
                end
            end
            ST_VERIFY: begin
                if (is_match) begin
                    match_next = match_cnt + MW'(1);
                    if (match_cnt >= MATCH_LAST) state_next = ST_LOCKED;
                end else begin
                    match_next = '0;
                    state_next = can_slip ? ST_SLIP : ST_FAIL;
                end
            end
            ST_LOCKED: begin
                if (is_match) begin
                    miss_next = '0;
                end else if (miss_cnt >= MISS_LAST) begin
                    // Lock lost: restart alignment with a fresh slip budget.
                    miss_next  = '0;
                    match_next = '0;
                    slip_next  = '0;
                    state_next = ST_CHECK;
                end else begin
                    miss_next = miss_cnt + LW'(1);
                end
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Disable wins over everything, including a slip about to be issued.
        if (!en_i) begin
            state_next  = ST_IDLE;
            slip_next   = '0;
            match_next  = '0;
            miss_next   = '0;
            settle_next = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            slip_cnt     <= '0;
            match_cnt    <= '0;
            miss_cnt     <= '0;
            settle_cnt   <= '0;
            bitslip_o    <= 1'b0;
            locked_o     <= 1'b0;
            fail_o       <= 1'b0;
            slip_count_o <= '0;
        end else begin
            state        <= state_next;
            slip_cnt     <= slip_next;
            match_cnt    <= match_next;
            miss_cnt     <= miss_next;
            settle_cnt   <= settle_next;
            bitslip_o    <= (state_next == ST_SLIP);
            locked_o     <= (state_next == ST_LOCKED);
            fail_o       <= (state_next == ST_FAIL);
            slip_count_o <= slip_next;
        end
    end

endmodule

// File: tb/tb_frame_aligner.sv
// Bench for frame_aligner: a rotating-deserializer model plus timing expectations
// derived from the alignment rules (attempt period, lock run, loss run).
module tb_frame_aligner;

    localparam logic [7:0] PAT = 8'hF0;

    logic       CLK;
    logic       RST;
    logic       en_i;
    logic [7:0] frame_i;
    logic       bitslip_o;
    logic       locked_o;
    logic       fail_o;
    logic [4:0] slip_count_o;

    int tests_run = 0;
    int failures  = 0;

    // Frame source: either a direct word, or a deserializer model that rotates
    // the pattern and removes one bit of rotation per slip, two cycles later.
    logic       use_model;
    logic       corrupt;
    logic [7:0] frame_drv;
    int         start_off;
    int         slips_seen;
    logic       sl_d1, sl_d2;

    function automatic logic [7:0] rotl(input logic [7:0] w, input int k);
        int          kk;
        logic [15:0] d;
        kk = ((k % 8) + 8) % 8;
        d  = {w, w};
        return d[15-kk -: 8];
    endfunction

    assign frame_i = use_model ? (corrupt ? ~rotl(PAT, start_off - slips_seen)
                                          :  rotl(PAT, start_off - slips_seen))
                               : frame_drv;

    always @(negedge CLK) begin
        if (!use_model) begin
            slips_seen = 0;
            sl_d1      = 1'b0;
            sl_d2      = 1'b0;
        end else begin
            if (sl_d2) slips_seen = slips_seen + 1;
            sl_d2 = sl_d1;
            sl_d1 = bitslip_o;
        end
    end

    frame_aligner dut (
        .CLK          (CLK),
        .RST          (RST),
        .en_i         (en_i),
        .frame_i      (frame_i),
        .bitslip_o    (bitslip_o),
        .locked_o     (locked_o),
        .fail_o       (fail_o),
        .slip_count_o (slip_count_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic go_idle();
        en_i      = 1'b0;
        use_model = 1'b0;
        corrupt   = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset();
        tests_run++;
        if (bitslip_o !== 1'b0) begin failures++; $display("FAIL reset_bitslip got %b exp 0", bitslip_o); end
        tests_run++;
        if (locked_o !== 1'b0) begin failures++; $display("FAIL reset_locked got %b exp 0", locked_o); end
        tests_run++;
        if (fail_o !== 1'b0) begin failures++; $display("FAIL reset_fail got %b exp 0", fail_o); end
        tests_run++;
        if (slip_count_o !== 5'd0) begin failures++; $display("FAIL reset_slip_count got %0d exp 0", slip_count_o); end
    endtask

    task automatic test_aligned();
        int pulses;
        pulses    = 0;
        frame_drv = PAT;
        use_model = 1'b0;
        en_i      = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            @(negedge CLK);
            if (bitslip_o) pulses++;
            if (k == 15) begin
                tests_run++;
                if (locked_o !== 1'b0) begin failures++; $display("FAIL aligned_early_lock edge %0d got %b exp 0", k, locked_o); end
            end
            if (k == 16) begin
                tests_run++;
                if (locked_o !== 1'b1) begin failures++; $display("FAIL aligned_lock edge %0d got %b exp 1", k, locked_o); end
            end
        end
        tests_run++;
        if (pulses != 0) begin failures++; $display("FAIL aligned_pulses got %0d exp 0", pulses); end
        tests_run++;
        if (slip_count_o !== 5'd0) begin failures++; $display("FAIL aligned_slip_count got %0d exp 0", slip_count_o); end
        en_i = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (locked_o !== 1'b0) begin failures++; $display("FAIL aligned_disable_lock got %b exp 0", locked_o); end
        go_idle();
    endtask

    task automatic test_deser(input int offset);
        int pulses;
        int lock_k;
        bit timing_ok;
        bit count_ok;
        pulses    = 0;
        timing_ok = 1'b1;
        count_ok  = 1'b1;
        lock_k    = 6 * offset + 16;
        start_off = offset;
        corrupt   = 1'b0;
        use_model = 1'b1;
        en_i      = 1'b1;
        for (int k = 0; k <= lock_k + 4; k++) begin
            @(negedge CLK);
            if (bitslip_o) begin
                // Attempt j: CHECK after edge 6j, SLIP after edge 6j+1.
                if (k != 6 * pulses + 1) timing_ok = 1'b0;
                if (slip_count_o !== 5'(pulses)) count_ok = 1'b0;
                pulses++;
            end
            if (k == lock_k - 1) begin
                tests_run++;
                if (locked_o !== 1'b0) begin failures++; $display("FAIL deser_early_lock off %0d got %b exp 0", offset, locked_o); end
            end
            if (k == lock_k) begin
                tests_run++;
                if (locked_o !== 1'b1) begin failures++; $display("FAIL deser_lock off %0d got %b exp 1", offset, locked_o); end
            end
        end
        tests_run++;
        if (pulses != offset) begin failures++; $display("FAIL deser_pulses got %0d exp %0d", pulses, offset); end
        tests_run++;
        if (!timing_ok) begin failures++; $display("FAIL deser_pulse_spacing got 0 exp 1"); end
        tests_run++;
        if (!count_ok) begin failures++; $display("FAIL deser_count_during_pulse got 0 exp 1"); end
        tests_run++;
        if (slip_count_o !== 5'(offset)) begin failures++; $display("FAIL deser_slip_count got %0d exp %0d", slip_count_o, offset); end
        go_idle();
    endtask

    task automatic test_fail();
        int pulses;
        int last_k;
        pulses    = 0;
        last_k    = -1;
        frame_drv = 8'h00;
        use_model = 1'b0;
        en_i      = 1'b1;
        for (int k = 0; k <= 110; k++) begin
            @(negedge CLK);
            if (bitslip_o) begin pulses++; last_k = k; end
            if (k == 96) begin
                tests_run++;
                if (fail_o !== 1'b0) begin failures++; $display("FAIL fail_early got %b exp 0", fail_o); end
            end
            if (k == 97) begin
                tests_run++;
                if (fail_o !== 1'b1) begin failures++; $display("FAIL fail_rise got %b exp 1", fail_o); end
            end
        end
        tests_run++;
        if (pulses != 16) begin failures++; $display("FAIL fail_pulses got %0d exp 16", pulses); end
        tests_run++;
        if (last_k != 91) begin failures++; $display("FAIL fail_last_pulse got %0d exp 91", last_k); end
        tests_run++;
        if (slip_count_o !== 5'd16) begin failures++; $display("FAIL fail_slip_count got %0d exp 16", slip_count_o); end
        tests_run++;
        if (fail_o !== 1'b1) begin failures++; $display("FAIL fail_sticky got %b exp 1", fail_o); end
        en_i = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (fail_o !== 1'b0) begin failures++; $display("FAIL fail_clear got %b exp 0", fail_o); end
        tests_run++;
        if (slip_count_o !== 5'd0) begin failures++; $display("FAIL fail_clear_count got %0d exp 0", slip_count_o); end
        go_idle();
    endtask

    task automatic test_loss();
        bit held_ok;
        int pulses;
        int n;
        held_ok   = 1'b1;
        pulses    = 0;
        start_off = 2;
        corrupt   = 1'b0;
        use_model = 1'b1;
        en_i      = 1'b1;
        repeat (30) @(negedge CLK);
        tests_run++;
        if (locked_o !== 1'b1 || slip_count_o !== 5'd2) begin
            failures++; $display("FAIL loss_initial_lock got %b/%0d exp 1/2", locked_o, slip_count_o);
        end
        // Fixed 3-bad/1-good/3-bad/1-good, then random short bursts.
        for (int i = 0; i < 8; i++) begin
            corrupt = (i % 4 != 3);
            @(negedge CLK);
            if (locked_o !== 1'b1) held_ok = 1'b0;
        end
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i <= n; i++) begin
                corrupt = (i < n);
                @(negedge CLK);
                if (locked_o !== 1'b1) held_ok = 1'b0;
            end
        end
        tests_run++;
        if (!held_ok) begin failures++; $display("FAIL loss_lock_held got 0 exp 1"); end
        for (int i = 1; i <= 4; i++) begin
            corrupt = 1'b1;
            @(negedge CLK);
            if (i == 3) begin
                tests_run++;
                if (locked_o !== 1'b1) begin failures++; $display("FAIL loss_third_miss got %b exp 1", locked_o); end
            end
        end
        tests_run++;
        if (locked_o !== 1'b0) begin failures++; $display("FAIL loss_drop got %b exp 0", locked_o); end
        tests_run++;
        if (slip_count_o !== 5'd0) begin failures++; $display("FAIL loss_fresh_budget got %0d exp 0", slip_count_o); end
        corrupt = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge CLK);
            if (bitslip_o) pulses++;
            if (k == 15) begin
                tests_run++;
                if (locked_o !== 1'b0) begin failures++; $display("FAIL loss_relock_early got %b exp 0", locked_o); end
            end
            if (k == 16) begin
                tests_run++;
                if (locked_o !== 1'b1) begin failures++; $display("FAIL loss_relock got %b exp 1", locked_o); end
            end
        end
        tests_run++;
        if (pulses != 0) begin failures++; $display("FAIL loss_relock_pulses got %0d exp 0", pulses); end
        go_idle();
    endtask

    task automatic test_verify_mismatch();
        int         pulses;
        int         pulse_k;
        logic [7:0] bad;
        pulses  = 0;
        pulse_k = -1;
        bad     = 8'($urandom);
        if (bad == PAT) bad = 8'h5A;
        use_model = 1'b0;
        en_i      = 1'b1;
        for (int k = 0; k <= 34; k++) begin
            frame_drv = (k == 10) ? bad : PAT;
            @(negedge CLK);
            if (bitslip_o) begin pulses++; pulse_k = k; end
            if (k == 30) begin
                tests_run++;
                if (locked_o !== 1'b0) begin failures++; $display("FAIL vmis_early_lock got %b exp 0", locked_o); end
            end
            if (k == 31) begin
                tests_run++;
                if (locked_o !== 1'b1) begin failures++; $display("FAIL vmis_lock got %b exp 1", locked_o); end
            end
        end
        tests_run++;
        if (pulses != 1 || pulse_k != 10) begin
            failures++; $display("FAIL vmis_pulse got %0d@%0d exp 1@10", pulses, pulse_k);
        end
        tests_run++;
        if (slip_count_o !== 5'd1) begin failures++; $display("FAIL vmis_slip_count got %0d exp 1", slip_count_o); end
        go_idle();
    endtask

    task automatic test_abort();
        frame_drv = 8'h00;
        use_model = 1'b0;
        en_i      = 1'b1;
        repeat (4) @(negedge CLK);
        tests_run++;
        if (slip_count_o !== 5'd1) begin failures++; $display("FAIL abort_in_settle got %0d exp 1", slip_count_o); end
        #2 RST = 1'b1;
        #1;
        tests_run++;
        if ({bitslip_o, locked_o, fail_o, slip_count_o} !== 8'd0) begin
            failures++; $display("FAIL abort_rst_async got %b exp 0", {bitslip_o, locked_o, fail_o, slip_count_o});
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        tests_run++;
        if (bitslip_o !== 1'b1) begin failures++; $display("FAIL abort_restart_slip got %b exp 1", bitslip_o); end
        en_i = 1'b0;
        @(negedge CLK);
        tests_run++;
        if ({bitslip_o, locked_o, fail_o, slip_count_o} !== 8'd0) begin
            failures++; $display("FAIL abort_en_in_slip got %b exp 0", {bitslip_o, locked_o, fail_o, slip_count_o});
        end
        en_i = 1'b1;
        @(negedge CLK);
        en_i = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (bitslip_o !== 1'b0) begin failures++; $display("FAIL abort_pending_slip got %b exp 0", bitslip_o); end
        go_idle();
    endtask

    initial begin
        RST       = 1'b1;
        en_i      = 1'b0;
        frame_drv = 8'h00;
        use_model = 1'b0;
        corrupt   = 1'b0;
        start_off = 0;
        repeat (2) @(negedge CLK);
        test_reset();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        test_aligned();
        test_deser(3);
        test_deser($urandom_range(1, 7));
        test_fail();
        test_loss();
        test_verify_mismatch();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/frame_aligner.md
# frame_aligner

Automatic word aligner for the ADC LVDS frame lane. Sits in the divided-clock domain directly after the 8-bit frame deserializer. Compares each parallel frame word against the known frame pattern and issues single-cycle bitslip pulses until the word matches. Declares lock after a run of consecutive matches, drops lock and re-aligns after a run of misses, and flags failure when the slip budget is exhausted. It generalises the fixed manual-bitslip frame path to any word width, pattern and retry policy.

## Interface
Parameters:
- WIDTH, 8, deserialized word width in bits
- PATTERN, 8'hF0, expected frame word (WIDTH bits)
- MAX_SLIPS, 2*WIDTH, slips allowed per alignment attempt before failure
- SETTLE_CYCLES, 4, cycles ignored after each slip (deserializer output latency), ≥1
- LOCK_COUNT, 16, consecutive matches required to lock, ≥1
- LOSS_COUNT, 4, consecutive mismatches in lock that trigger re-alignment, ≥1

Ports:
- CLK  in  1  divided (parallel-word) clock; the only clock
- RST  in  1  asynchronous, active-high reset
- en_i  in  1  alignment enable; low forces IDLE
- frame_i  in  WIDTH  parallel frame word from deserializer, valid every cycle
- bitslip_o  out  1  one-cycle bitslip request to deserializer
- locked_o  out  1  frame aligned
- fail_o  out  1  slip budget exhausted; sticky until en_i low or RST
- slip_count_o  out  $clog2(MAX_SLIPS+1)  slips issued in current attempt

## Operation
- States: IDLE, CHECK, SLIP, SETTLE, VERIFY, LOCKED, FAIL.
- IDLE: all outputs 0, counters cleared. en_i=1 → CHECK.
- CHECK: frame_i==PATTERN → VERIFY, match_cnt=1 (LOCK_COUNT=1 → LOCKED directly). Mismatch: slip_cnt<MAX_SLIPS → SLIP, else → FAIL.
- SLIP: bitslip_o=1 for exactly this cycle; slip_cnt+1; → SETTLE, settle_cnt loaded with SETTLE_CYCLES.
- SETTLE: frame_i ignored; after SETTLE_CYCLES cycles → CHECK.
- VERIFY: match → match_cnt+1; when it reaches LOCK_COUNT → LOCKED. Mismatch → SLIP or FAIL (same rule as CHECK); match_cnt cleared.
- LOCKED: locked_o=1. Mismatch → miss_cnt+1; any match clears miss_cnt. miss_cnt reaches LOSS_COUNT → CHECK, slip_cnt cleared (fresh budget), locked_o low from next cycle.
- FAIL: fail_o=1, no further slips, held until en_i=0.
- en_i=0 in any state → IDLE next cycle; overrides all other transitions; a pending slip is not issued.
- Exact match only; no rotated-pattern shortcut.
- Counters saturate and never wrap; slip_cnt never exceeds MAX_SLIPS.

## Timing
- All outputs registered, decoded from state and counters; reset value 0 for every output and counter, state IDLE.
- RST mid-operation: immediate return to IDLE, bitslip_o dropped asynchronously.
- en_i sampled high at edge 0 → CHECK after edge 0; with frame_i matching throughout, locked_o rises after edge LOCK_COUNT.
- Each failed attempt costs SETTLE_CYCLES+2 cycles (CHECK, SLIP, SETTLE).
- bitslip_o pulses are separated by ≥SETTLE_CYCLES+1 low cycles.
- slip_count_o updates in the cycle after bitslip_o is high.

## Structure
- Package frame_align_pkg: state enum typedef, default frame pattern constant, counter-width helper function.
- Single module, no sub-modules; deserializer primitive is instantiated by the parent.

## Test plan
- Aligned input (frame_i=8'hF0 constant), defaults: en_i at edge 0 → no bitslip_o pulse, locked_o=1 after edge 16, slip_count_o=0.
- Behavioural deserializer model rotating the word by one bit per pulse (2-cycle latency), start offset 3 → exactly 3 pulses, 6 cycles apart, lock follows, slip_count_o=3.
- frame_i=8'h00 constant → 16 pulses, then fail_o=1 with slip_count_o=16, no further pulses; en_i low → fail_o=0 next cycle.
- Locked, then 3 corrupted words, 1 good, 3 corrupted → lock held; 4 consecutive corrupted → locked_o drops, re-alignment starts with slip_count_o=0.
- Mismatch at 10th VERIFY word → match_cnt cleared, one bitslip_o pulse, lock requires a full 16 further matches.
- RST asserted during SETTLE, and en_i dropped during SLIP → all outputs 0 (immediately for RST, next cycle for en_i), state IDLE.
